// File: rtl/remap_bilinear.sv
// Bilinear interpolation stage: horizontal blend, vertical blend, then round/fill.
// Fixed 3-cycle pipeline with full backpressure; user/last/oob travel with each beat.
module remap_bilinear #(
  parameter int unsigned PIX_WIDTH = 8,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned FRAC_WIDTH = 8,
  parameter logic [PIX_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [CHANNELS*PIX_WIDTH-1:0]   s_p00,
  input  logic [CHANNELS*PIX_WIDTH-1:0]   s_p01,
  input  logic [CHANNELS*PIX_WIDTH-1:0]   s_p10,
  input  logic [CHANNELS*PIX_WIDTH-1:0]   s_p11,
  input  logic [FRAC_WIDTH-1:0]           s_fx,
  input  logic [FRAC_WIDTH-1:0]           s_fy,
  input  logic                            s_oob,
  input  logic                            s_user,
  input  logic                            s_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [CHANNELS*PIX_WIDTH-1:0]   m_pix,
  output logic                            m_user,
  output logic                            m_last
);

  localparam int unsigned DATA_W = CHANNELS * PIX_WIDTH;
  localparam int unsigned H_W    = PIX_WIDTH + FRAC_WIDTH;
  localparam int unsigned A_W    = PIX_WIDTH + 2 * FRAC_WIDTH;
  localparam logic [FRAC_WIDTH:0] W_ONE = (FRAC_WIDTH + 1)'(1) << FRAC_WIDTH;
  localparam logic [A_W:0]        HALF  = (A_W + 1)'(1) << (2 * FRAC_WIDTH - 1);

  logic                  en;
  logic [FRAC_WIDTH:0]   wx0, wx1, wy0, wy1;
  logic [H_W-1:0]        top_c [CHANNELS];
  logic [H_W-1:0]        bot_c [CHANNELS];
  logic [A_W-1:0]        acc_c [CHANNELS];
  logic [A_W:0]          rnd_c [CHANNELS];
  logic [PIX_WIDTH:0]    q_c   [CHANNELS];
  logic [DATA_W-1:0]     pix_c;

  logic                  s1_valid, s1_oob, s1_user, s1_last;
  logic [FRAC_WIDTH-1:0] s1_fy;
  logic [H_W-1:0]        s1_top [CHANNELS];
  logic [H_W-1:0]        s1_bot [CHANNELS];
  logic                  s2_valid, s2_oob, s2_user, s2_last;
  logic [A_W-1:0]        s2_acc [CHANNELS];

  // Whole pipeline moves in lockstep; bubbles are kept in place.
  assign en      = !m_valid || m_ready;
  assign s_ready = en;

  // Stage 1: horizontal blend of the top and bottom neighbour pairs.
  always_comb begin
    wx0 = W_ONE - (FRAC_WIDTH + 1)'(s_fx);
    wx1 = (FRAC_WIDTH + 1)'(s_fx);
    for (int c = 0; c < CHANNELS; c++) begin
      top_c[c] = H_W'(s_p00[c*PIX_WIDTH +: PIX_WIDTH]) * H_W'(wx0)
               + H_W'(s_p01[c*PIX_WIDTH +: PIX_WIDTH]) * H_W'(wx1);
      bot_c[c] = H_W'(s_p10[c*PIX_WIDTH +: PIX_WIDTH]) * H_W'(wx0)
               + H_W'(s_p11[c*PIX_WIDTH +: PIX_WIDTH]) * H_W'(wx1);
    end
  end

  // Stage 2: vertical blend, full precision.
  always_comb begin
    wy0 = W_ONE - (FRAC_WIDTH + 1)'(s1_fy);
    wy1 = (FRAC_WIDTH + 1)'(s1_fy);
    for (int c = 0; c < CHANNELS; c++) begin
      acc_c[c] = A_W'(s1_top[c]) * A_W'(wy0) + A_W'(s1_bot[c]) * A_W'(wy1);
    end
  end

  // Stage 3: round half-up, saturate as a guard, substitute fill when out of bounds.
  always_comb begin
    pix_c = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      rnd_c[c] = (A_W + 1)'(s2_acc[c]) + HALF;
      q_c[c]   = (PIX_WIDTH + 1)'(rnd_c[c] >> (2 * FRAC_WIDTH));
      if (s2_oob)
        pix_c[c*PIX_WIDTH +: PIX_WIDTH] = FILL_VALUE;
      else if (q_c[c][PIX_WIDTH])
        pix_c[c*PIX_WIDTH +: PIX_WIDTH] = {PIX_WIDTH{1'b1}};
      else
        pix_c[c*PIX_WIDTH +: PIX_WIDTH] = q_c[c][PIX_WIDTH-1:0];
    end
  end

  // Control and output registers; outputs only update on valid beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      m_valid  <= 1'b0;
      m_pix    <= '0;
      m_user   <= 1'b0;
      m_last   <= 1'b0;
    end else if (en) begin
      s1_valid <= s_valid;
      s2_valid <= s1_valid;
      m_valid  <= s2_valid;
      if (s2_valid) begin
        m_pix  <= pix_c;
        m_user <= s2_user;
        m_last <= s2_last;
      end
    end
  end

  // Datapath and sideband registers; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_fy   <= s_fy;
      s1_oob  <= s_oob;
      s1_user <= s_user;
      s1_last <= s_last;
      s2_oob  <= s1_oob;
      s2_user <= s1_user;
      s2_last <= s1_last;
      for (int c = 0; c < CHANNELS; c++) begin
        s1_top[c] <= top_c[c];
        s1_bot[c] <= bot_c[c];
        s2_acc[c] <= acc_c[c];
      end
    end
  end

endmodule
